// File: rtl/freq_gen_pkg.sv
// -----------------------------------------------------------------------------
// freq_gen_pkg
// Shared definitions for the programmable square-wave generator.
//   DIVD_W     : width of the reference-frequency dividend (26 bits)
//   QUOT_W     : width of the half-period quotient and toggle counter (25 bits)
//   FREQ_W_DEF : default width of the frequency request/echo in Hz (20 bits)
//   state_t    : control state machine encoding (IDLE / DIV / WAIT_EDGE)
// -----------------------------------------------------------------------------
package freq_gen_pkg;

   localparam int DIVD_W     = 26;
   localparam int QUOT_W     = 25;
   localparam int FREQ_W_DEF = 20;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DIV       = 2'd1,
      WAIT_EDGE = 2'd2
   } state_t;

endpackage

// File: rtl/freq_gen_div.sv
// -----------------------------------------------------------------------------
// freq_div_seq
// Restoring divider, one quotient bit per cycle, fixed DIVD_W-cycle latency.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_start       : load operands and begin (ignored while busy)
//   i_dividend    : DIVD_W-bit dividend
//   i_divisor     : DVSR_W-bit divisor (must be non-zero)
//   o_busy        : iterations in progress
//   o_done        : high during the final iteration; o_quotient is valid
//                   from the following cycle until the next start
//   o_quotient    : low QUOT_W bits of the quotient
// -----------------------------------------------------------------------------
module freq_div_seq
   import freq_gen_pkg::*;
#(
   parameter int DVSR_W = 21
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [DIVD_W-1:0] i_dividend,
   input  logic [DVSR_W-1:0] i_divisor,
   output logic              o_busy,
   output logic              o_done,
   output logic [QUOT_W-1:0] o_quotient
);

   localparam int CNT_W = $clog2(DIVD_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVD_W - 1);

   logic [DIVD_W-1:0] r_rem;
   logic [DIVD_W-1:0] r_quo;     // shifts dividend out, quotient bits in
   logic [DVSR_W-1:0] r_dvsr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;

   // The trial remainder needs one bit more than the dividend so the
   // shifted-in bit can never be lost before the compare.
   logic [DIVD_W:0]   w_rem_sh;
   logic [DIVD_W:0]   w_dvsr_ext;
   logic              w_ge;
   logic [DIVD_W-1:0] w_rem_next;

   assign w_rem_sh   = {r_rem, r_quo[DIVD_W-1]};
   assign w_dvsr_ext = (DIVD_W+1)'(r_dvsr);
   assign w_ge       = (w_rem_sh >= w_dvsr_ext);
   // After a successful subtract the remainder is below the divisor, so
   // dropping the top bit is lossless.
   assign w_rem_next = w_ge ? DIVD_W'(w_rem_sh - w_dvsr_ext)
                            : w_rem_sh[DIVD_W-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvsr <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_rem  <= '0;
         r_quo  <= i_dividend;
         r_dvsr <= i_divisor;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_rem <= w_rem_next;
         r_quo <= {r_quo[DIVD_W-2:0], w_ge};
         if (r_cnt == LAST_STEP) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_cnt == LAST_STEP);
   assign o_quotient = r_quo[QUOT_W-1:0];

endmodule

// File: rtl/freq_gen.sv
// -----------------------------------------------------------------------------
// freq_gen
// Programmable square-wave generator. A frequency request in Hz is turned
// into a half-period (CLK_FS / (2*freq) reference cycles) by a sequential
// divider and applied glitch-free on a toggle boundary of the running output.
// Ports:
//   sys_clk   : reference clock (CLK_FS Hz)
//   sys_rst   : asynchronous active-high reset
//   freq_set  : requested frequency in Hz
//   set_valid : request strobe, taken when set_ready is high
//   set_ready : high only while idle
//   set_done  : one-cycle pulse when a new frequency takes effect
//   set_err   : one-cycle pulse when a request is rejected (0 or > CLK_FS/2)
//   freq_cur  : frequency currently generated, 0 = disabled
//   clk_out   : generated square wave (registered)
// -----------------------------------------------------------------------------
module freq_gen
   import freq_gen_pkg::*;
#(
   parameter logic [DIVD_W-1:0] CLK_FS = 26'd50000000,
   parameter int                FREQ_W = FREQ_W_DEF
)(
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [FREQ_W-1:0] freq_set,
   input  logic              set_valid,
   output logic              set_ready,
   output logic              set_done,
   output logic              set_err,
   output logic [FREQ_W-1:0] freq_cur,
   output logic              clk_out
);

   state_t            r_state;
   state_t            w_state_next;

   logic [FREQ_W-1:0] r_freq_req;
   logic [FREQ_W-1:0] r_freq_cur;
   logic [QUOT_W-1:0] r_half_cur;
   logic [QUOT_W-1:0] r_cnt;
   logic              r_clk_out;
   logic              r_set_done;
   logic              r_set_err;

   logic              w_accept;
   logic              w_bad;
   logic              w_start;
   logic              w_reject;
   logic              w_enabled;
   logic              w_toggle;
   logic              w_apply;
   logic              w_div_busy;
   logic              w_div_done;
   logic [QUOT_W-1:0] w_quotient;

   assign w_accept  = set_valid && (r_state == IDLE);
   assign w_bad     = (freq_set == '0) || (32'(freq_set) > 32'(CLK_FS >> 1));
   assign w_start   = w_accept && !w_bad && !w_div_busy;
   assign w_reject  = w_accept && w_bad;

   // A zero half-period means the generator is parked with clk_out low.
   assign w_enabled = (r_half_cur != '0);
   assign w_toggle  = w_enabled && (r_cnt == r_half_cur - QUOT_W'(1));

   // Switching only on an old toggle cycle keeps every phase at least
   // min(half_old, half_new) long.
   assign w_apply   = (r_state == WAIT_EDGE) && (!w_enabled || w_toggle);

   freq_div_seq #(
      .DVSR_W (FREQ_W + 1)
   ) u_div (
      .i_clk      (sys_clk),
      .i_rst      (sys_rst),
      .i_start    (w_start),
      .i_dividend (CLK_FS),
      .i_divisor  ({freq_set, 1'b0}),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quotient (w_quotient)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_next = DIV;
            end
         end
         DIV: begin
            if (w_div_done) begin
               w_state_next = WAIT_EDGE;
            end
         end
         WAIT_EDGE: begin
            if (w_apply) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state    <= IDLE;
         r_freq_req <= '0;
         r_freq_cur <= '0;
         r_half_cur <= '0;
         r_cnt      <= '0;
         r_clk_out  <= 1'b0;
         r_set_done <= 1'b0;
         r_set_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_set_done <= w_apply;
         r_set_err  <= w_reject;

         if (w_start) begin
            r_freq_req <= freq_set;
         end

         if (w_apply) begin
            r_half_cur <= w_quotient;
            r_cnt      <= '0;
            r_freq_cur <= r_freq_req;
         end else if (w_toggle) begin
            r_cnt <= '0;
         end else if (w_enabled) begin
            r_cnt <= r_cnt + QUOT_W'(1);
         end

         // The apply cycle from an enabled state is itself an old toggle,
         // so the output still flips there.
         if (w_toggle) begin
            r_clk_out <= ~r_clk_out;
         end
      end
   end

   assign set_ready = (r_state == IDLE);
   assign set_done  = r_set_done;
   assign set_err   = r_set_err;
   assign freq_cur  = r_freq_cur;
   assign clk_out   = r_clk_out;

endmodule

// File: tb/tb_freq_gen.sv
module tb_freq_gen;

   localparam int CLK_FS_HZ = 50_000_000;

   logic        sys_clk   = 1'b0;
   logic        sys_rst   = 1'b1;
   logic [19:0] freq_set  = '0;
   logic        set_valid = 1'b0;
   logic        set_ready;
   logic        set_done;
   logic        set_err;
   logic [19:0] freq_cur;
   logic        clk_out;

   freq_gen #(
      .CLK_FS (26'd50000000),
      .FREQ_W (20)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .freq_set  (freq_set),
      .set_valid (set_valid),
      .set_ready (set_ready),
      .set_done  (set_done),
      .set_err   (set_err),
      .freq_cur  (freq_cur),
      .clk_out   (clk_out)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit is_err;
      int freq;
      int cyc;
   } exp_t;

   exp_t sb_q[$];
   int   ph_q[$];

   int   cyc       = 0;
   int   n_vec     = 0;
   int   n_err     = 0;
   int   mdl_freq  = 0;
   int   mdl_half  = 0;
   int   last_edge = 0;
   int   done_cyc  = 0;
   int   run_len   = 0;
   logic prev_out  = 1'b0;

   always @(posedge sys_clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Phase-length recorder and event scoreboard.
   always @(negedge sys_clk) begin : mon
      exp_t e;
      if (sys_rst) begin
         prev_out = 1'b0;
         run_len  = 0;
      end else begin
         if (clk_out !== prev_out) begin
            ph_q.push_back(run_len);
            run_len   = 1;
            prev_out  = clk_out;
            last_edge = cyc;
         end else begin
            run_len++;
         end
         if (set_done || set_err) begin
            check("done_err_excl", set_done & set_err, 0);
            if (sb_q.size() == 0) begin
               check("unexpected_evt", {set_done, set_err}, 0);
            end else begin
               e = sb_q.pop_front();
               check("evt_kind", set_err, e.is_err);
               check("evt_cycle", cyc, e.cyc);
               check("freq_cur", freq_cur, e.freq);
               if (set_done) done_cyc = cyc;
            end
         end
      end
   end

   // Cycle in which set_done should appear: 28 after accept when disabled,
   // otherwise one after the first old toggle cycle at or beyond accept+27.
   function automatic int exp_done(input int acc);
      int a;
      if (mdl_half == 0) return acc + 28;
      a = last_edge - 1;
      while (a < acc + 27) a += mdl_half;
      return a + 1;
   endfunction

   task automatic request(input int f, input int hold = 0, input int alt_f = 0);
      exp_t e;
      int   acc;
      @(posedge sys_clk); #1;
      set_valid = 1'b1;
      freq_set  = 20'(f);
      acc       = cyc;
      if (f == 0 || f > CLK_FS_HZ / 2) begin
         e.is_err = 1'b1;
         e.freq   = mdl_freq;
         e.cyc    = acc + 1;
      end else begin
         e.is_err = 1'b0;
         e.freq   = f;
         e.cyc    = exp_done(acc);
         mdl_freq = f;
         mdl_half = CLK_FS_HZ / (2 * f);
      end
      sb_q.push_back(e);
      $display("request freq=%0d accept_cycle=%0d expect_%s_cycle=%0d", f, acc,
               e.is_err ? "err" : "done", e.cyc);
      @(negedge sys_clk);
      check("ready_at_accept", set_ready, 1);
      @(posedge sys_clk); #1;
      if (hold > 0) begin
         freq_set = 20'(alt_f);
         repeat (hold) begin
            @(posedge sys_clk); #1;
         end
      end
      set_valid = 1'b0;
      if (hold == 0) begin
         @(negedge sys_clk);
         check("ready_after", set_ready, e.is_err);
      end
   endtask

   task automatic wait_sb(input int max_cyc);
      int n = 0;
      while (sb_q.size() != 0 && n < max_cyc) begin
         @(negedge sys_clk);
         n++;
      end
      check("sb_drain", sb_q.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;
      sb_q.delete();
      mdl_freq = 0;
      mdl_half = 0;
      repeat (2) @(negedge sys_clk);
      check("rst_clk_out", clk_out, 0);
      check("rst_freq_cur", freq_cur, 0);
      check("rst_ready", set_ready, 1);
      check("rst_done", set_done, 0);
      check("rst_err", set_err, 0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
   endtask

   task automatic measure(input int half);
      int   n   = 0;
      int   bad = 0;
      logic p;
      p = clk_out;
      while (clk_out === p && n < 4 * half + 10) begin
         @(negedge sys_clk);
         n++;
      end
      check("edge_seen", clk_out !== p, 1);
      @(posedge sys_clk);
      ph_q.delete();
      repeat (5 * half + 5) @(negedge sys_clk);
      foreach (ph_q[i]) if (ph_q[i] != half) bad++;
      check("phase_len", bad, 0);
      check("phase_cnt", ph_q.size() >= 4, 1);
      $display("measure half=%0d phases=%0d off_length=%0d", half, ph_q.size(), bad);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int n;
      int bad;

      do_reset();

      // Enable from disabled at 1 MHz: half = 25.
      request(1_000_000);
      wait_sb(100);
      n = 0;
      while (clk_out !== 1'b1 && n < 100) begin
         @(negedge sys_clk);
         n++;
      end
      check("first_rise", cyc - done_cyc, 25);
      measure(25);

      // Zero is rejected; output keeps running.
      request(0);
      wait_sb(10);
      measure(25);

      // Mid-phase change to 500 kHz: applied on an old toggle, then half = 50.
      n = 0;
      while (clk_out !== 1'b1 && n < 60) begin
         @(negedge sys_clk);
         n++;
      end
      repeat (12) @(negedge sys_clk);
      ph_q.delete();
      request(500_000);
      wait_sb(200);
      repeat (260) @(negedge sys_clk);
      bad = 0;
      foreach (ph_q[i]) if (ph_q[i] != 25 && ph_q[i] != 50) bad++;
      check("mid_phase_len", bad, 0);
      check("new_phase_a", ph_q[ph_q.size() - 1], 50);
      check("new_phase_b", ph_q[ph_q.size() - 2], 50);

      // Valid held during DIV with another value: only the first applies.
      request(1_000_000, 20, 250_000);
      wait_sb(200);
      measure(25);

      // Reset in DIV cycle 10: pending request discarded.
      request(200_000);
      repeat (8) begin
         @(posedge sys_clk); #1;
      end
      do_reset();
      repeat (60) @(negedge sys_clk);
      check("idle_clk_out", clk_out, 0);
      check("idle_freq_cur", freq_cur, 0);

      // Fresh request after reset: half = 40.
      request(625_000);
      wait_sb(60);
      measure(40);

      // Largest representable request: truncated half = 23.
      request(1_048_575);
      wait_sb(100);
      measure(23);

      // 3 Hz: half = 8_333_333, so no toggle within the observation window.
      request(3);
      wait_sb(100);
      repeat (3) @(negedge sys_clk);
      ph_q.delete();
      repeat (3000) @(negedge sys_clk);
      check("slow_no_toggle", ph_q.size(), 0);

      // Lowest frequency from disabled.
      do_reset();
      request(1);
      wait_sb(60);

      check("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/freq_gen.md
# freq_gen

Programmable square-wave generator producing a test clock at a requested frequency in Hz. It is the stimulus counterpart of the equal-precision cymometer: it takes a 20-bit frequency value in the same Hz format the cymometer reports, derives the half-period in reference-clock cycles with a sequential divider, and drives a glitch-free `clk_out`. It sits beside the cymometer in the top level so a board loopback can close the measure/generate loop.

## Interface
- `CLK_FS`, default 26'd50000000: reference clock frequency in Hz.
- `FREQ_W`, default 20: width of the frequency request and echo.
- `sys_clk`  in  1  reference clock; the only clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `freq_set`  in  FREQ_W  requested frequency in Hz.
- `set_valid`  in  1  request strobe; accepted when `set_valid && set_ready`.
- `set_ready`  out  1  high only in IDLE.
- `set_done`  out  1  one-cycle pulse when a new frequency takes effect.
- `set_err`  out  1  one-cycle pulse when a request is rejected.
- `freq_cur`  out  FREQ_W  frequency currently generated; 0 = disabled.
- `clk_out`  out  1  generated square wave, registered.

## Operation
- Reset values: `clk_out`=0, `set_ready`=1 once the state machine is in IDLE, `set_done`=0, `set_err`=0, `freq_cur`=0. The half-period register and counter are 0, and the output is disabled.
- States are IDLE, DIV and WAIT_EDGE.
- IDLE: on accept, latch `freq_set`.
  - If the value is 0 or greater than CLK_FS/2: pulse `set_err`, stay in IDLE, keep the current output unchanged.
  - Otherwise go to DIV.
- DIV: restoring division `half = CLK_FS / (2*freq)`, truncated. Runs one quotient bit per cycle for exactly 26 cycles (the dividend width), then goes to WAIT_EDGE.
- WAIT_EDGE: if the output is disabled, apply immediately. Otherwise apply in the cycle where the current counter reaches `half_cur-1`, which is the toggle cycle.
  - Apply means: load `half_cur`, clear the counter, update `freq_cur`, pulse `set_done`, return to IDLE.
- Generator: while enabled, the counter runs 0..`half_cur-1`. At `half_cur-1` it toggles `clk_out` and wraps to 0.
  - Output period = 2*`half_cur` cycles; duty is exactly 50%.
- Width rules: the divisor is FREQ_W+1 bits and the remainder is 27 bits. The quotient and counter are 25 bits, which is enough for the maximum `half` = CLK_FS/2.
- `set_valid` while `set_ready`=0 is ignored; no queuing.

## Timing
- Accept in cycle 0. DIV occupies cycles 1..26. WAIT_EDGE is entered in cycle 27.
- From disabled: apply in cycle 27. `set_done` and `freq_cur` are visible in cycle 28. The first `clk_out` toggle occurs `half` cycles after apply.
- From enabled: apply latency = 27 + the wait for the next old toggle, at most `half_old` cycles. No high or low phase is ever shorter than min(`half_old`, `half_new`) cycles.
- Reject: `set_err` is high in cycle 1; `set_ready` stays high throughout.
- Reset asserted in any state: immediate return to reset values. A pending request is discarded and no `set_done` is produced.
- `set_done` and `set_err` are never high in the same cycle.

## Structure
- Package `freq_gen_pkg` holds the state enumeration (IDLE/DIV/WAIT_EDGE) and the localparams for dividend width (26), quotient width (25) and `FREQ_W`.
- Sub-module `freq_div_seq`: start/busy/done restoring divider with a fixed 26-cycle latency, instantiated once.
- The top level holds the FSM, half-period register, counter and output flop.

## Test plan
- Reset, then request 1_000_000 → `set_done` at cycle 28, `freq_cur`=1_000_000, half=25, `clk_out` period 50 cycles, 25 high/25 low.
- Request 3 → half=8_333_333; first toggle 8_333_333 cycles after apply; `freq_cur`=3.
- Request 0 → `set_err` pulse in cycle 1, no `set_done`, `clk_out` and `freq_cur` unchanged.
- Running at 1_000_000, request 500_000 at mid-phase → new half=50 applied exactly at the next old toggle; no phase shorter than 25 cycles; then period 100.
- `set_valid` held during DIV with a different value → ignored; only the first value is applied.
- Assert `sys_rst` at DIV cycle 10 → `clk_out`=0, `freq_cur`=0, no `set_done`; a fresh request after release completes normally.
